// File: rtl/display_7seg_scan.sv
// Converts an 8-bit value to BCD with a sequential double-dabble engine and
// drives a multiplexed common-anode 7-segment display with leading-zero blanking.
module display_7seg_scan #(
    parameter int SCAN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] valor_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       busy_o
);

    localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t           state;
    logic [7:0]       valor_lat;
    logic [19:0]      sh;
    logic [19:0]      sh_adj;
    logic [2:0]       it;
    logic [3:0]       d_u, d_t, d_h;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       idx;
    logic             busy_r;
    logic [3:0]       digit;
    logic             blank;

    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Correct each BCD nibble before the shift so the shift itself carries in decimal
    always_comb begin
        sh_adj = {dabble_adj(sh[19:16]), dabble_adj(sh[15:12]), dabble_adj(sh[11:8]), sh[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state     <= IDLE;
            valor_lat <= 8'd0;
            sh        <= 20'd0;
            it        <= 3'd0;
            d_u       <= 4'd0;
            d_t       <= 4'd0;
            d_h       <= 4'd0;
            busy_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valor_i != valor_lat) begin
                        valor_lat <= valor_i;
                        sh        <= {12'd0, valor_i};
                        it        <= 3'd0;
                        state     <= CONV;
                        busy_r    <= 1'b1;
                    end
                end
                CONV: begin
                    sh <= {sh_adj[18:0], 1'b0};
                    it <= it + 3'd1;
                    if (it == 3'd7) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    d_h    <= sh[19:16];
                    d_t    <= sh[15:12];
                    d_u    <= sh[11:8];
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Scan runs free of the FSM; only reset restarts it
    always_ff @(posedge clk) begin
        if (reset_i) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        case (idx)
            2'd0:    digit = d_u;
            2'd1:    digit = d_t;
            default: digit = d_h;
        endcase
        blank = ((idx == 2'd2) && (d_h == 4'd0)) ||
                ((idx == 2'd1) && (d_h == 4'd0) && (d_t == 4'd0));
        if (blank || idx == 2'd3) begin
            an_o  = 4'b1111;
            seg_o = 7'h7F;
        end else begin
            an_o  = ~(4'b0001 << idx);
            seg_o = seg_decode(digit);
        end
    end

    assign busy_o = busy_r;

endmodule

// File: tb/tb_display_7seg_scan.sv
// Directed bench for display_7seg_scan: conversion latency, blanking,
// back-to-back acceptance, mid-conversion reset and scan period sweep.
module tb_display_7seg_scan;

    logic       clk;
    logic       reset_i;
    logic [7:0] valor_i;
    logic [6:0] seg_o, seg1, seg3;
    logic [3:0] an_o, an1, an3;
    logic       busy_o, busy1, busy3;

    int total;
    int bad;
    int k;       // edges since reset released
    int shown;   // value the display should currently hold

    display_7seg_scan #(.SCAN_CYCLES(2)) dut (
        .clk(clk), .reset_i(reset_i), .valor_i(valor_i),
        .seg_o(seg_o), .an_o(an_o), .busy_o(busy_o));
    display_7seg_scan #(.SCAN_CYCLES(1)) dut1 (
        .clk(clk), .reset_i(reset_i), .valor_i(valor_i),
        .seg_o(seg1), .an_o(an1), .busy_o(busy1));
    display_7seg_scan #(.SCAN_CYCLES(3)) dut3 (
        .clk(clk), .reset_i(reset_i), .valor_i(valor_i),
        .seg_o(seg3), .an_o(an3), .busy_o(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit slot_blank(input int slot, input int val);
        if (slot == 2) return (val / 100) == 0;
        if (slot == 1) return val < 10;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_an(input int sc, input int val);
        int slot;
        slot = (k / sc) % 3;
        if (slot_blank(slot, val)) return 4'b1111;
        case (slot)
            0: return 4'b1110;
            1: return 4'b1101;
            default: return 4'b1011;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int sc, input int val);
        int slot;
        slot = (k / sc) % 3;
        if (slot_blank(slot, val)) return 7'h7F;
        case (slot)
            0: return ref_seg(val % 10);
            1: return ref_seg((val / 10) % 10);
            default: return ref_seg(val / 100);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset_i) k = 0;
        else k++;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        valor_i = 8'd0;
        shown   = 0;
        tick();
        tick();
        total++;
        if (an_o !== 4'b1110 || seg_o !== 7'b1000000 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state an=%b seg=%b busy=%b want an=1110 seg=1000000 busy=0",
                     an_o, seg_o, busy_o);
        end
        reset_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (an_o !== exp_an(2, 0) || seg_o !== exp_seg(2, 0) || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_scan k=%0d an=%b seg=%b busy=%b want an=%b seg=%b busy=0",
                         k, an_o, seg_o, busy_o, exp_an(2, 0), exp_seg(2, 0));
            end
        end
    endtask

    task automatic test_conv_123();
        valor_i = 8'd123;
        for (int c = 0; c < 9; c++) begin
            tick();
            total++;
            if (busy_o !== 1'b1 || an_o !== exp_an(2, shown) || seg_o !== exp_seg(2, shown)) begin
                bad++;
                $display("FAIL conv123_busy c=%0d busy=%b an=%b seg=%b want busy=1 an=%b seg=%b",
                         c, busy_o, an_o, seg_o, exp_an(2, shown), exp_seg(2, shown));
            end
        end
        tick();
        shown = 123;
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL conv123_done busy=%b want 0", busy_o);
        end
        for (int c = 0; c < 6; c++) begin
            total++;
            if (an_o !== exp_an(2, shown) || seg_o !== exp_seg(2, shown)) begin
                bad++;
                $display("FAIL conv123_disp k=%0d an=%b seg=%b want an=%b seg=%b",
                         k, an_o, seg_o, exp_an(2, shown), exp_seg(2, shown));
            end
            tick();
        end
    endtask

    task automatic test_scan_sweep();
        for (int c = 0; c < 9; c++) begin
            tick();
            total++;
            if (an1 !== exp_an(1, shown) || seg1 !== exp_seg(1, shown)) begin
                bad++;
                $display("FAIL scan_sc1 k=%0d an=%b seg=%b want an=%b seg=%b",
                         k, an1, seg1, exp_an(1, shown), exp_seg(1, shown));
            end
            total++;
            if (an3 !== exp_an(3, shown) || seg3 !== exp_seg(3, shown)) begin
                bad++;
                $display("FAIL scan_sc3 k=%0d an=%b seg=%b want an=%b seg=%b",
                         k, an3, seg3, exp_an(3, shown), exp_seg(3, shown));
            end
        end
    endtask

    task automatic test_blanking();
        int vals [3] = '{255, 7, 100};
        foreach (vals[v]) begin
            valor_i = vals[v][7:0];
            for (int c = 0; c < 10; c++) tick();
            shown = vals[v];
            total++;
            if (busy_o !== 1'b0) begin
                bad++;
                $display("FAIL blank_busy val=%0d busy=%b want 0", shown, busy_o);
            end
            for (int c = 0; c < 6; c++) begin
                total++;
                if (an_o !== exp_an(2, shown) || seg_o !== exp_seg(2, shown)) begin
                    bad++;
                    $display("FAIL blank_disp val=%0d k=%0d an=%b seg=%b want an=%b seg=%b",
                             shown, k, an_o, seg_o, exp_an(2, shown), exp_seg(2, shown));
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        valor_i = 8'd10;
        for (int c = 0; c < 10; c++) tick();
        shown = 10;
        valor_i = 8'd200;
        tick();                              // edge N
        tick();
        tick();
        valor_i = 8'd45;                     // present at edge N+3
        for (int c = 0; c < 7; c++) tick();  // through edge N+9
        shown = 200;
        total++;
        if (busy_o !== 1'b0 || an_o !== exp_an(2, shown) || seg_o !== exp_seg(2, shown)) begin
            bad++;
            $display("FAIL b2b_first busy=%b an=%b seg=%b want busy=0 an=%b seg=%b",
                     busy_o, an_o, seg_o, exp_an(2, shown), exp_seg(2, shown));
        end
        tick();                              // edge N+10
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept busy=%b want 1", busy_o);
        end
        for (int c = 0; c < 8; c++) tick();  // edge N+18
        total++;
        if (an_o !== exp_an(2, shown) || seg_o !== exp_seg(2, shown)) begin
            bad++;
            $display("FAIL b2b_hold an=%b seg=%b want an=%b seg=%b",
                     an_o, seg_o, exp_an(2, shown), exp_seg(2, shown));
        end
        tick();                              // edge N+19
        shown = 45;
        total++;
        if (busy_o !== 1'b0 || an_o !== exp_an(2, shown) || seg_o !== exp_seg(2, shown)) begin
            bad++;
            $display("FAIL b2b_second busy=%b an=%b seg=%b want busy=0 an=%b seg=%b",
                     busy_o, an_o, seg_o, exp_an(2, shown), exp_seg(2, shown));
        end
    endtask

    task automatic test_reset_mid();
        valor_i = 8'd0;
        for (int c = 0; c < 10; c++) tick();
        shown = 0;
        valor_i = 8'd88;
        for (int c = 0; c < 4; c++) tick();  // edges N..N+3
        reset_i = 1'b1;
        tick();                              // edge N+4
        total++;
        if (busy_o !== 1'b0 || an_o !== 4'b1110 || seg_o !== 7'b1000000) begin
            bad++;
            $display("FAIL rstmid_state busy=%b an=%b seg=%b want busy=0 an=1110 seg=1000000",
                     busy_o, an_o, seg_o);
        end
        reset_i = 1'b0;
        tick();                              // edge N+5 accepts 88 again
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_accept busy=%b want 1", busy_o);
        end
        for (int c = 0; c < 8; c++) tick();
        total++;
        if (an_o !== exp_an(2, shown) || seg_o !== exp_seg(2, shown)) begin
            bad++;
            $display("FAIL rstmid_hold an=%b seg=%b want an=%b seg=%b",
                     an_o, seg_o, exp_an(2, shown), exp_seg(2, shown));
        end
        tick();                              // edge N+14
        shown = 88;
        for (int c = 0; c < 6; c++) begin
            total++;
            if (busy_o !== 1'b0 || an_o !== exp_an(2, shown) || seg_o !== exp_seg(2, shown)) begin
                bad++;
                $display("FAIL rstmid_disp k=%0d busy=%b an=%b seg=%b want busy=0 an=%b seg=%b",
                         k, busy_o, an_o, seg_o, exp_an(2, shown), exp_seg(2, shown));
            end
            tick();
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        k       = 0;
        shown   = 0;
        reset_i = 1'b1;
        valor_i = 8'd0;
        test_reset();
        test_conv_123();
        test_scan_sweep();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_7seg_scan.md
# display_7seg_scan

Consumer of the 8-bit event counter value: converts `valor_i` (0..255) to three BCD digits with a sequential double-dabble engine and drives a time-multiplexed, common-anode 4-digit seven-segment display. It runs on the same 1 kHz enable-rate system clock as the debouncer, synchronizer and counter, and connects directly to the counter's `conta_o`. Leading zeros are blanked and the leftmost digit is never used.

## Interface
Parameters:
- `SCAN_CYCLES`, default 2: clock cycles each digit stays active before the scan advances. Legal range is ≥1.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `valor_i`  in  8  binary value to display, unsigned, sampled every cycle.
- `seg_o`  out  7  segment drives, active-low. Bit 0 is segment a, bit 6 is segment g.
- `an_o`  out  4  digit anodes, active-low. Bit 0 is units, bit 1 tens, bit 2 hundreds; bit 3 is always 1.
- `busy_o`  out  1  high while a conversion or display update is in progress.

## Operation
- Registers:
  - `valor_lat[7:0]` holds the last accepted value.
  - Shift register `sh` holds {12-bit BCD, 8-bit binary}.
  - Iteration counter `it` is 0..7.
  - Display digits `d_u`, `d_t`, `d_h` are 4 bits each.
  - Scan counter runs 0..SCAN_CYCLES-1.
  - Digit index `idx` runs 0..2.
- FSM has three states: IDLE, CONV and UPDATE. `busy_o` = (state != IDLE).
- IDLE:
  - If `valor_i != valor_lat`: latch `valor_lat <= valor_i`, load `sh <= {12'd0, valor_i}`, set `it <= 0`, go to CONV.
  - Otherwise stay in IDLE.
- CONV, one iteration per cycle:
  - Add 3 to each BCD nibble of `sh` that is ≥5.
  - Then shift the whole of `sh` left by 1.
  - `it <= it+1`. When `it == 7`, go to UPDATE.
- UPDATE (one cycle): copy the BCD nibbles to `d_h`, `d_t`, `d_u` atomically, then go to IDLE.
- Changes on `valor_i` during CONV or UPDATE are ignored. On return to IDLE, the current `valor_i` is compared against `valor_lat` again, so the final value is always converted eventually.
- Scan:
  - The scan counter increments every cycle.
  - At SCAN_CYCLES-1 it wraps to 0 and `idx` advances 0→1→2→0.
  - The active anode is `an_o[idx]` = 0; all other anodes are 1.
- Blanking:
  - Hundreds is blank when `d_h == 0`.
  - Tens is blank when `d_h == 0` and `d_t == 0`.
  - Units is never blank.
  - A blanked slot drives `an_o = 4'b1111` and `seg_o = 7'h7F` for its whole duration. The scan timing is unchanged.
- Segment decode (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other nibble value = 1111111.
- Reset:
  - state = IDLE, `valor_lat` = 0, `sh` = 0, `it` = 0.
  - `d_*` = 0, scan counter = 0, `idx` = 0.
  - Reset overrides every other action, including mid-conversion. The partial result is discarded and the display regs go to 0.

## Timing
- Reset values of outputs: `an_o = 4'b1110`, `seg_o = 7'b1000000` (units shows "0"), `busy_o = 0`.
- `an_o` and `seg_o` are combinational decodes of the registered `idx` and `d_*`. They update in the same cycle that `idx` or `d_*` changes.
- Conversion latency:
  - A change is seen in IDLE at edge N.
  - `busy_o` is high from after edge N until edge N+9.
  - `d_*` are updated at edge N+9. The new digits are visible from that cycle on.
  - Total: 9 cycles from acceptance to display.
- Back-to-back changes: the minimum spacing between accepted values is 10 cycles (9 busy cycles plus 1 IDLE compare).
- Full scan period is 3·SCAN_CYCLES cycles. With the default this is 6 ms at 1 kHz.
- The scan runs continuously and is independent of the FSM. Reset restarts it at `idx` 0.

## Test plan
- Reset with `valor_i = 0` held: `an_o` cycles 1110 (seg 1000000), then 1111 (seg 1111111), then 1111 (seg 1111111). Each step lasts 2 cycles. `busy_o` stays 0.
- `valor_i` 0→123 at edge N: `busy_o` is 1 for 9 cycles. From N+9 on, the units slot shows 0110000 ("3"), tens shows 0100100 ("2") and hundreds shows 1111001 ("1").
- `valor_i = 255`: the digits become 2, 5, 5. `valor_i = 7`: units shows 1111000, and the tens and hundreds slots are fully blanked.
- `valor_i = 100` (d_t = 0, d_h = 1): tens shows "0" (1000000) and is not blanked.
- `valor_i` 10→200 at N, then 200→45 at N+3: the display shows 200 at N+9. A second conversion is then accepted at N+10 and the display shows 45 at N+19.
- `reset_i` asserted at N+4 of a 0→88 conversion: the next cycle is IDLE, `busy_o = 0`, and the display shows "0". With 88 still on `valor_i` after reset is released, a new conversion starts and the display shows 88 nine cycles later. Sweep SCAN_CYCLES ∈ {1, 3} to confirm the period is 3·SCAN_CYCLES.
